neuron_sequencer: RTL

- Sequences one neuron evaluation over a shared activation datapath.
- Streams NUM_INPUTS feature values one per cycle and multiplies each by a stored weight. Accumulates the products, adds a stored bias, then applies the selected act_func. Holds the prediction until the downstream consumer accepts it.
- Sits between the feature source and the next layer or output, and owns the weight/bias register file.

---
 rtl/neuron_sequencer_pkg.sv | 19 +
 rtl/neuron_sequencer_predict.sv | 37 +++
 rtl/neuron_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/neuron_sequencer_pkg.sv
// Shared types for the neuron sequencer: activation select and FSM states.
package neuron_sequencer_pkg;

  // Activation functions understood by the predict block.
  typedef enum logic [1:0] {
    Identity       = 2'd0,
    Heaviside_Step = 2'd1,
    ReLU           = 2'd2
  } act_func;

  // Sequencer states for one neuron evaluation.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    ACTIVATE = 2'd2,
    OUTPUT   = 2'd3
  } nstate_t;

endpackage

// File: rtl/neuron_sequencer_predict.sv
// Combinational activation block: applies the selected act_func to a sum.
module neuron_sequencer_predict
  import neuron_sequencer_pkg::*;
(
  input  act_func activation_i,
  input  real     sum_i,
  output real     result_o
);

  // Select the activation transfer function; unknown encodings pass through.
  always_comb begin
    result_o = 0.0;
    case (activation_i)
      Identity: begin
        result_o = sum_i;
      end
      Heaviside_Step: begin
        if (sum_i > 0.0) begin
          result_o = 1.0;
        end else begin
          result_o = 0.0;
        end
      end
      ReLU: begin
        if (sum_i > 0.0) begin
          result_o = sum_i;
        end else begin
          result_o = 0.0;
        end
      end
      default: begin
        result_o = sum_i;
      end
    endcase
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Neuron sequencer: streams NUM_INPUTS features against a stored weight file,
// accumulates, adds bias, activates, and holds the prediction for the consumer.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  act_func          activation,
  input  logic             w_we,
  input  logic [IDX_W-1:0] w_addr,
  input  real              w_data,
  input  logic             b_we,
  output logic             cfg_err,
  input  logic             x_valid,
  output logic             x_ready,
  input  real              x_data,
  output logic             out_valid,
  input  logic             out_ready,
  output real              prediction,
  output logic             busy
);

  nstate_t          state_q, state_d;
  real              acc_q, acc_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  act_func          act_q, act_d;
  real              pred_q, pred_d;
  logic             out_valid_q, out_valid_d;
  real              w_q [NUM_INPUTS];
  real              bias_q;
  logic             cfg_err_q;
  logic             beat_s;
  logic             idle_s;
  real              w_sel_s;
  real              sum_s;
  real              act_out_s;

  assign idle_s     = (state_q == IDLE);
  assign x_ready    = (state_q == IDLE) || (state_q == ACCUM);
  assign beat_s     = x_valid && x_ready;
  assign busy       = !idle_s;
  assign out_valid  = out_valid_q;
  assign prediction = pred_q;
  assign cfg_err    = cfg_err_q;

  // Pick the weight for the current beat; cnt wraps past the last index only after the final beat.
  always_comb begin
    w_sel_s = 0.0;
    if (int'(cnt_q) < NUM_INPUTS) begin
      w_sel_s = w_q[cnt_q];
    end else begin
      w_sel_s = 0.0;
    end
  end

  // Pre-activation value presented to the predict block.
  always_comb begin
    sum_s = acc_q + bias_q;
  end

  neuron_sequencer_predict u_predict (
    .activation_i (act_q),
    .sum_i        (sum_s),
    .result_o     (act_out_s)
  );

  // Next-state and datapath update for the evaluation FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    pred_d      = pred_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (beat_s) begin
          acc_d = x_data * w_sel_s;
          act_d = activation;
          cnt_d = IDX_W'(1);
          if (NUM_INPUTS == 1) begin
            state_d = ACTIVATE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s) begin
          acc_d = acc_q + x_data * w_sel_s;
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(NUM_INPUTS - 1)) begin
            state_d = ACTIVATE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      ACTIVATE: begin
        pred_d      = act_out_s;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = 0.0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 0.0;
      cnt_q       <= '0;
      act_q       <= Identity;
      pred_q      <= 0.0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      pred_q      <= pred_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Weight/bias file: writes land only while idle; busy-time writes raise a sticky error.
  // Out-of-range weight indices are silently ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        w_q[i] <= 0.0;
      end
      bias_q    <= 0.0;
      cfg_err_q <= 1'b0;
    end else begin
      if (w_we && (int'(w_addr) < NUM_INPUTS)) begin
        if (idle_s) begin
          w_q[w_addr] <= w_data;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (b_we) begin
        if (idle_s) begin
          bias_q <= w_data;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

endmodule
